// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell plus a carry flop, LSB first.
// {carry_out, sum} = augend + addend + carry_in, delivered over valid/ready.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// ADD   | one bit per clock through the full-adder cell
// DONE  | result held on sum/carry_out until out_ready
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] augend,
  input  logic [WIDTH-1:0] addend,
  input  logic             carry_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] aug_sh;
  logic [WIDTH-1:0] add_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_next;
  logic             carry_r;
  logic [CW-1:0]    bit_cnt;
  logic             bit_sum;
  logic             bit_carry;
  logic             last_bit;

  assign bit_sum   = aug_sh[0] ^ add_sh[0] ^ carry_r;
  assign bit_carry = (aug_sh[0] & add_sh[0]) | (carry_r & (aug_sh[0] ^ add_sh[0]));
  assign last_bit  = (bit_cnt == CW'(WIDTH - 1));

  // New sum bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign sum_next = bit_sum;
    end else begin : g_sum_wn
      assign sum_next = {bit_sum, sum_sh[WIDTH-1:1]};
    end
  endgenerate

  assign sum       = sum_sh;
  assign carry_out = carry_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      aug_sh    <= '0;
      add_sh    <= '0;
      sum_sh    <= '0;
      carry_r   <= 1'b0;
      bit_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            aug_sh   <= augend;
            add_sh   <= addend;
            carry_r  <= carry_in;
            bit_cnt  <= '0;
            state    <= ADD;
            in_ready <= 1'b0;
          end
        end
        ADD: begin
          sum_sh  <= sum_next;
          aug_sh  <= aug_sh >> 1;
          add_sh  <= add_sh >> 1;
          carry_r <= bit_carry;
          bit_cnt <= bit_cnt + CW'(1);
          if (last_bit) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 and WIDTH=1 instances checked
// against plain integer addition.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic [7:0] augend, addend;
  logic       carry_in, in_valid, out_ready;
  logic       in_ready, carry_out, out_valid;
  logic [7:0] sum;

  logic [0:0] augend1, addend1, sum1;
  logic       carry_in1, in_valid1, out_ready1;
  logic       in_ready1, carry_out1, out_valid1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .augend(augend), .addend(addend), .carry_in(carry_in),
    .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum), .carry_out(carry_out),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .augend(augend1), .addend(addend1), .carry_in(carry_in1),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .sum(sum1), .carry_out(carry_out1),
    .out_valid(out_valid1), .out_ready(out_ready1)
  );

  // Present operands at a negedge, return latency (edges after acceptance)
  // and the result; out_ready is left low so the result is held.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output int lat, output logic [8:0] res);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL run_op_ready: in_ready=%b want 1", in_ready);
    end
    augend = a; addend = b; carry_in = c; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    in_valid = 1'b0;
    augend = 8'($urandom); addend = 8'($urandom); carry_in = 1'($urandom);
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    res = {carry_out, sum};
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic c);
    int lat;
    logic [8:0] res, exp;
    exp = 9'(a) + 9'(b) + 9'(c);
    run_op(a, b, c, lat, res);
    vectors++;
    if (lat != 8) begin
      miscompares++;
      $display("FAIL %s_latency: got %0d cycles want 8", name, lat);
    end
    vectors++;
    if (res !== exp) begin
      miscompares++;
      $display("FAIL %s_result: %h+%h+%b got %h want %h", name, a, b, c, res, exp);
    end
    consume();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_return: in_ready=%b out_valid=%b want 1/0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 8'h00 || carry_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset8: rdy=%b vld=%b sum=%h co=%b want 1/0/00/0",
               in_ready, out_valid, sum, carry_out);
    end
    vectors++;
    if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || sum1 !== 1'b0 || carry_out1 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset1: rdy=%b vld=%b sum=%b co=%b want 1/0/0/0",
               in_ready1, out_valid1, sum1, carry_out1);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    check_op("basic_5a3c", 8'h5A, 8'h3C, 1'b0);
    check_op("carry_ffff1", 8'hFF, 8'hFF, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] a_tab [2];
    logic [7:0] b_tab [2];
    logic       c_tab [2];
    int ready_t [$];
    int nacc = 0, nres = 0;
    logic [8:0] exp;
    a_tab[0] = 8'hFF; b_tab[0] = 8'h01; c_tab[0] = 1'b0;
    a_tab[1] = 8'hFF; b_tab[1] = 8'hFF; c_tab[1] = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (out_valid === 1'b1) begin
        exp = (nres < 2) ? 9'(a_tab[nres]) + 9'(b_tab[nres]) + 9'(c_tab[nres]) : 9'h0;
        vectors++;
        if (nres >= 2 || {carry_out, sum} !== exp) begin
          miscompares++;
          $display("FAIL b2b_result%0d: got %h want %h", nres, {carry_out, sum}, exp);
        end
        nres++;
      end
      if (in_ready === 1'b1) begin
        ready_t.push_back(cyc);
        if (nacc < 2) begin
          augend = a_tab[nacc]; addend = b_tab[nacc]; carry_in = c_tab[nacc];
          in_valid = 1'b1;
          nacc++;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    vectors++;
    if (nres != 2) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d results want 2", nres);
    end
    vectors++;
    if (ready_t.size() < 3 || ready_t[1] - ready_t[0] != 10 || ready_t[2] - ready_t[1] != 10) begin
      miscompares++;
      $display("FAIL b2b_period: in_ready pulses=%0d spacing not 10 (first=%0d,%0d,%0d)",
               ready_t.size(), ready_t.size() > 0 ? ready_t[0] : -1,
               ready_t.size() > 1 ? ready_t[1] : -1, ready_t.size() > 2 ? ready_t[2] : -1);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [8:0] res, exp;
    logic [7:0] a, b;
    logic c;
    a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
    exp = 9'(a) + 9'(b) + 9'(c);
    run_op(a, b, c, lat, res);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {carry_out, sum} !== exp) begin
        miscompares++;
        $display("FAIL bp_hold%0d: vld=%b rdy=%b res=%h want 1/0/%h",
                 i, out_valid, in_ready, {carry_out, sum}, exp);
      end
      @(negedge clk);
    end
    consume();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_release: rdy=%b vld=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_busy_ignore();
    logic [7:0] a, b;
    logic [8:0] exp;
    int lat = 0;
    a = 8'($urandom); b = 8'($urandom);
    exp = 9'(a) + 9'(b);
    augend = a; addend = b; carry_in = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk); lat++;
    augend = 8'h11; addend = 8'h22; carry_in = 1'b1; in_valid = 1'b1;
    repeat (3) begin @(negedge clk); lat++; end
    in_valid = 1'b0;
    while (out_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    vectors++;
    if (lat != 8 || {carry_out, sum} !== exp) begin
      miscompares++;
      $display("FAIL busy_result: lat=%0d res=%h want 8/%h", lat, {carry_out, sum}, exp);
    end
    consume();
    for (int i = 0; i < 12; i++) begin
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL busy_no_second%0d: vld=%b rdy=%b want 0/1", i, out_valid, in_ready);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_op();
    augend = 8'hFF; addend = 8'hFF; carry_in = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 8'h00 || carry_out !== 1'b0) begin
      miscompares++;
      $display("FAIL midop_reset: rdy=%b vld=%b sum=%h co=%b want 1/0/00/0",
               in_ready, out_valid, sum, carry_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL midop_stale%0d: out_valid=%b want 0", i, out_valid);
      end
    end
    check_op("midop_new", 8'h01, 8'h01, 1'b0);
  endtask

  task automatic test_random();
    int lat;
    logic [8:0] res, exp;
    logic [7:0] a, b;
    logic c;
    for (int n = 0; n < 20; n++) begin
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
      exp = 9'(a) + 9'(b) + 9'(c);
      run_op(a, b, c, lat, res);
      vectors++;
      if (lat != 8 || res !== exp) begin
        miscompares++;
        $display("FAIL rand%0d: %h+%h+%b lat=%0d res=%h want 8/%h", n, a, b, c, lat, res, exp);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      consume();
    end
  endtask

  task automatic test_width1();
    int lat;
    logic [1:0] exp;
    for (int k = 0; k < 8; k++) begin
      augend1 = 1'(k >> 2); addend1 = 1'(k >> 1); carry_in1 = 1'(k);
      exp = 2'(augend1) + 2'(addend1) + 2'(carry_in1);
      in_valid1 = 1'b1; out_ready1 = 1'b0;
      @(posedge clk);
      lat = 0;
      @(negedge clk);
      in_valid1 = 1'b0;
      while (out_valid1 !== 1'b1 && lat < 10) begin
        @(posedge clk); lat++; @(negedge clk);
      end
      vectors++;
      if (lat != 1 || {carry_out1, sum1} !== exp) begin
        miscompares++;
        $display("FAIL w1_case%0d: lat=%0d res=%b want 1/%b", k, lat, {carry_out1, sum1}, exp);
      end
      out_ready1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready1 = 1'b0;
    end
  endtask

  initial begin
    augend = '0; addend = '0; carry_in = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    augend1 = '0; addend1 = '0; carry_in1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_busy_ignore();
    test_reset_mid_op();
    test_random();
    test_width1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
